// File: rtl/haz_issue_queue.sv
// rtl/haz_issue_queue.sv - instruction issue FIFO feeding the FSM hazard resolver
//
// Purpose: buffers fetch tokens and presents the head token to the hazard
// resolver, whose stall acts as back-pressure. Carries an issue FSM, flush
// handling and a saturating stall-cycle counter for bring-up visibility.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   in_valid/in_ready    fetch handshake, in_instr is the token
//   out_valid/out_ready  resolver handshake, out_instr is the head token
//   flush                discard all buffered tokens
//   count                occupancy (0..DEPTH)
//   state                FSM state: EMPTY=0, ISSUE=1, STALL=2, FLUSH=3
//   stall_cnt            saturating count of out_valid && !out_ready cycles
//
// Optional feature: HAZ_ISSUEQ_BYPASS_EN lets a token pass straight through
// an empty, idle queue when the resolver is ready.

module haz_issue_queue #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_instr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [W-1:0]           out_instr,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count,
   output logic [1:0]             state,
   output logic [7:0]             stall_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ISSUE = 2'b01,
      ST_STALL = 2'b10,
      ST_FLUSH = 2'b11
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [W-1:0]   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count_q;
   logic [CW-1:0]  count_d;
   logic [7:0]     stall_q;

   logic           buf_valid;
   logic           bypass;
   logic           push;
   logic           pop;
   logic           stall_evt;

   // Acceptance depends only on registered occupancy and state, so a pop in
   // the same cycle never frees a slot for a push (no full pass-through).
   assign in_ready  = (count_q < CW'(DEPTH)) && (state_q != ST_FLUSH);
   assign buf_valid = (count_q != '0) && (state_q != ST_FLUSH);

`ifdef HAZ_ISSUEQ_BYPASS_EN
   // Count zero already implies EMPTY or FLUSH; the state term keeps the
   // flush-recovery cycle closed.
   assign bypass = (count_q == '0) && (state_q == ST_EMPTY) && in_valid && out_ready;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid = buf_valid || bypass;
   assign out_instr = bypass ? in_instr : mem[rd_ptr];

   // A bypassed token is consumed directly and never touches the array.
   assign push      = in_valid && in_ready && !bypass;
   assign pop       = buf_valid && out_ready;
   assign stall_evt = out_valid && !out_ready;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_comb begin
      state_d = ST_ISSUE;
      if (state_q == ST_FLUSH) begin
         state_d = ST_EMPTY;
      end else if (count_d == '0) begin
         state_d = ST_EMPTY;
      end else if (stall_evt) begin
         state_d = ST_STALL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         state_q <= ST_EMPTY;
         stall_q <= '0;
      end else begin
         if (stall_evt && (stall_q != 8'hFF)) begin
            stall_q <= stall_q + 8'd1;
         end
         if (flush) begin
            // Any push or pop requested alongside a flush is dropped.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            state_q <= ST_FLUSH;
         end else begin
            if (push) begin
               mem[wr_ptr] <= in_instr;
               wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_d;
            state_q <= state_d;
         end
      end
   end

   assign count     = count_q;
   assign state     = state_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_haz_issue_queue.sv
// tb/tb_haz_issue_queue.sv - scoreboard bench for haz_issue_queue

module tb_haz_issue_queue;

   localparam int DEPTH = 4;
   localparam int W     = 8;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [W-1:0]           in_instr;
   logic                   out_valid;
   logic                   out_ready;
   logic [W-1:0]           out_instr;
   logic                   flush;
   logic [$clog2(DEPTH):0] count;
   logic [1:0]             state;
   logic [7:0]             stall_cnt;

   haz_issue_queue #(.DEPTH(DEPTH), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .flush     (flush),
      .count     (count),
      .state     (state),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Scoreboard: tokens fetch has handed over, in the order they must leave.
   logic [7:0] exp_q [$];

   // Reference model: occupancy, state code and stall counter.
   int m_count;
   int m_state;
   int m_stall;
   bit m_after_rst;

   function automatic bit m_in_ready();
      return (m_count < DEPTH) && (m_state != 3);
   endfunction

   function automatic bit m_bypass();
`ifdef HAZ_ISSUEQ_BYPASS_EN
      return (m_count == 0) && (m_state == 0) && in_valid && out_ready;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_out_valid();
      return ((m_count != 0) && (m_state != 3)) || m_bypass();
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus, entered and left just after a rising edge.
   task automatic cycle(input bit r, input bit iv, input logic [7:0] tok,
                        input bit ordy, input bit fl, output bit acc);
      bit ir;
      bit ov;
      bit byp;
      int nc;
      rst       = r;
      in_valid  = iv;
      in_instr  = tok;
      out_ready = ordy;
      flush     = fl;
      ir  = m_in_ready();
      byp = m_bypass();
      ov  = m_out_valid();
      acc = !r && !fl && iv && ir;
      if (acc) exp_q.push_back(tok);

      @(negedge clk);
      check("in_ready", int'(in_ready), int'(ir));
      check("out_valid", int'(out_valid), int'(ov));
      check("count", int'(count), m_count);
      check("state", int'(state), m_state);
      check("stall_cnt", int'(stall_cnt), m_stall);
      if (m_after_rst && !byp) check("out_instr_reset", int'(out_instr), 0);

      @(posedge clk);
      if (r) begin
         m_count = 0;
         m_state = 0;
         m_stall = 0;
         m_after_rst = 1;
         exp_q.delete();
      end else begin
         m_after_rst = 0;
         if (ov && !ordy && m_stall < 255) m_stall++;
         if (fl) begin
            m_count = 0;
            m_state = 3;
            exp_q.delete();
         end else begin
            nc = m_count;
            if (acc && !byp) nc++;
            if ((m_count != 0) && (m_state != 3) && ordy) nc--;
            if (m_state == 3)      m_state = 0;
            else if (nc == 0)      m_state = 0;
            else if (ov && !ordy)  m_state = 2;
            else                   m_state = 1;
            m_count = nc;
         end
      end
      #1;
   endtask

   // Monitor: every output handshake must deliver the oldest expected token.
   always @(negedge clk) begin
      logic [7:0] t;
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_token: got %02h expected none at %0t", out_instr, $time);
         end else begin
            t = exp_q.pop_front();
            if (out_instr !== t) begin
               errors++;
               $display("FAIL out_token: got %02h expected %02h at %0t", out_instr, t, $time);
            end
         end
      end
   end

   initial begin
      bit a;
      int k;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_instr  = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_count = 0;
      m_state = 0;
      m_stall = 0;
      m_after_rst = 1;

      // Streaming through an empty queue.
      cycle(0, 1, 8'h12, 1, 0, a);
      cycle(0, 1, 8'hF2, 1, 0, a);
      cycle(0, 1, 8'hF3, 1, 0, a);
      repeat (2) cycle(0, 0, 8'h00, 1, 0, a);

      // Fill under stall; the fifth token waits at fetch.
      k = 0;
      repeat (8) begin
         cycle(0, k < 5, 8'(160 + k), 0, 0, a);
         if (a) k++;
      end

      // Release from full while fetch keeps offering tokens.
      repeat (8) begin
         cycle(0, 1, 8'(160 + k), 1, 0, a);
         if (a) k++;
      end
      repeat (6) cycle(0, 0, 8'h00, 1, 0, a);

      // Flush with three buffered tokens and a token offered that cycle.
      repeat (3) cycle(0, 1, 8'($urandom), 0, 0, a);
      cycle(0, 1, 8'h5A, 0, 1, a);
      cycle(0, 1, 8'h5B, 1, 0, a);
      cycle(0, 1, 8'h5C, 1, 0, a);
      repeat (3) cycle(0, 0, 8'h00, 1, 0, a);

      // Long stall saturates the counter, then reset mid-stall.
      cycle(0, 1, 8'h77, 0, 0, a);
      repeat (300) cycle(0, 0, 8'h00, 0, 0, a);
      check("stall_saturated", int'(stall_cnt), 255);
      cycle(1, 1, 8'h88, 0, 1, a);
      cycle(0, 0, 8'h00, 0, 0, a);

      // Empty queue, resolver ready (bypass case when enabled).
      cycle(0, 1, 8'hEA, 1, 0, a);
      repeat (2) cycle(0, 0, 8'h00, 1, 0, a);

      // Randomized traffic with occasional flush and reset.
      repeat (3000) begin
         cycle(($urandom % 500) == 0, ($urandom % 4) != 0, 8'($urandom),
               ($urandom % 3) != 0, ($urandom % 40) == 0, a);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
